// File: rtl/decode_buffer.sv
// -----------------------------------------------------------------------------
// decode_buffer
//   Two-entry in-order skid buffer between instruction fetch and decode.
//   Words are pushed from fetch and popped by decode. The head word is
//   presented on out_instr and broken into the standard MIPS-style fields.
//   NOP_WORD is presented on out_instr and the field outputs whenever the
//   buffer is empty.
//
//   Optional feature: define DECODE_PC_TRACK_EN to add in_pc/out_pc. The PC is
//   then stored alongside each word, and out_pc reads 32'h0 when the buffer is
//   empty.
//
// Ports
//   clock          sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   in_instr       instruction word from fetch
//   in_valid       fetch presents a word
//   in_ready       buffer can accept a word (count < 2)
//   flush          discard every buffered word
//   out_valid      head entry holds a valid word
//   out_ready      decode consumes the head entry
//   out_instr      head word (NOP_WORD when empty)
//   out_opcode     out_instr[31:26]
//   out_rs         out_instr[25:21]
//   out_rt         out_instr[20:16]
//   out_rd         out_instr[15:11]
//   out_shamt      out_instr[10:6]
//   out_funct      out_instr[5:0]
//   out_immediate  out_instr[15:0]
//   in_pc/out_pc   PC of pushed/head word (DECODE_PC_TRACK_EN only)
//   out_count      number of occupied entries (0..2)
// -----------------------------------------------------------------------------
module decode_buffer #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] in_instr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [5:0]  out_opcode,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_shamt,
   output logic [5:0]  out_funct,
   output logic [15:0] out_immediate,
`ifdef DECODE_PC_TRACK_EN
   input  logic [31:0] in_pc,
   output logic [31:0] out_pc,
`endif
   output logic [1:0]  out_count
);

   logic [31:0] instr_mem [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;

   // Handshake terms depend only on registered count, so no path exists
   // from out_ready to in_ready.
   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Flush wins over any same-cycle push or pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset. Its contents are masked whenever count is zero.
   always_ff @(posedge clock) begin
      if (push && !flush) instr_mem[wr_ptr] <= in_instr;
   end

   assign out_instr     = out_valid ? instr_mem[rd_ptr] : NOP_WORD;
   assign out_opcode    = out_instr[31:26];
   assign out_rs        = out_instr[25:21];
   assign out_rt        = out_instr[20:16];
   assign out_rd        = out_instr[15:11];
   assign out_shamt     = out_instr[10:6];
   assign out_funct     = out_instr[5:0];
   assign out_immediate = out_instr[15:0];
   assign out_count     = count;

`ifdef DECODE_PC_TRACK_EN
   logic [31:0] pc_mem [2];

   always_ff @(posedge clock) begin
      if (push && !flush) pc_mem[wr_ptr] <= in_pc;
   end

   assign out_pc = out_valid ? pc_mem[rd_ptr] : 32'h0;
`endif

endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;

   localparam logic [31:0] NOP = 32'hFC00_003F;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] in_instr;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [4:0]  out_shamt;
   logic [5:0]  out_funct;
   logic [15:0] out_immediate;
   logic [1:0]  out_count;
`ifdef DECODE_PC_TRACK_EN
   logic [31:0] in_pc;
   logic [31:0] out_pc;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   decode_buffer #(.NOP_WORD(NOP)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_instr      (in_instr),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_opcode    (out_opcode),
      .out_rs        (out_rs),
      .out_rt        (out_rt),
      .out_rd        (out_rd),
      .out_shamt     (out_shamt),
      .out_funct     (out_funct),
      .out_immediate (out_immediate),
`ifdef DECODE_PC_TRACK_EN
      .in_pc         (in_pc),
      .out_pc        (out_pc),
`endif
      .out_count     (out_count)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t sb[$];

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [31:0] instr;
      logic [1:0]  ecount;
      logic [31:0] einstr;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] ei;
      ei = (sb.size() > 0) ? sb[0].instr : NOP;
      chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, sb.size() > 0});
      chk({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, sb.size() < 2});
      chk({tag, " out_count"}, {30'd0, out_count}, sb.size());
      chk({tag, " out_instr"}, out_instr, ei);
      chk({tag, " fields"},
          {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct},
          {ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[10:6], ei[5:0]});
      chk({tag, " out_immediate"}, {16'd0, out_immediate}, {16'd0, ei[15:0]});
`ifdef DECODE_PC_TRACK_EN
      chk({tag, " out_pc"}, out_pc, (sb.size() > 0) ? sb[0].pc : 32'h0);
`endif
   endtask

   // Drive one cycle, advance the scoreboard model across the edge, compare.
   task automatic step(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] instr, input logic [31:0] pc, input string tag);
      bit do_push;
      bit do_pop;
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      in_instr  = instr;
`ifdef DECODE_PC_TRACK_EN
      in_pc     = pc;
`endif
      do_push = iv && (sb.size() < 2);
      do_pop  = ordy && (sb.size() > 0);
      @(posedge clock);
      #1;
      if (fl) begin
         sb.delete();
      end else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back('{instr, pc});
      end
      check_model(tag);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h2010_FFFC, 2'd1, 32'h2010_FFFC};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'hAAAA_0001, 2'd2, 32'h2010_FFFC};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'hBBBB_0002, 2'd2, 32'h2010_FFFC};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd1, 32'hAAAA_0001};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h1234_5678, 2'd1, 32'h1234_5678};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd0, NOP};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd0, NOP};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'hAAAA_0001, 2'd1, 32'hAAAA_0001};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'hBBBB_0002, 2'd2, 32'hAAAA_0001};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd1, 32'hBBBB_0002};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 32'hCCCC_0003, 2'd2, 32'hBBBB_0002};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 32'hDDDD_0004, 2'd0, NOP};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h1111_0000, 2'd0, NOP};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0000_002A, 2'd1, 32'h0000_002A};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd0, NOP};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_instr  = 32'h0;
`ifdef DECODE_PC_TRACK_EN
      in_pc     = 32'h0;
`endif
      repeat (3) @(posedge clock);
      #1;
      check_model("reset");
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         step(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].instr,
              32'h0040_0000 + 32'(i * 4), $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl_count", i), {30'd0, out_count}, {30'd0, vecs[i].ecount});
         chk($sformatf("vec%0d tbl_instr", i), out_instr, vecs[i].einstr);
         chk($sformatf("vec%0d tbl_in_ready", i), {31'd0, in_ready},
             {31'd0, vecs[i].ecount < 2'd2});
         if (i == 0) begin
            chk("first opcode", {26'd0, out_opcode}, 32'h08);
            chk("first rs", {27'd0, out_rs}, 32'd0);
            chk("first rt", {27'd0, out_rt}, 32'd16);
            chk("first imm", {16'd0, out_immediate}, 32'h0000_FFFC);
         end
      end

      // Head must hold while out_ready stays low across several cycles.
      step(1'b1, 1'b0, 1'b0, 32'h0F0F_1234, 32'h0040_0000, "hold_push");
      step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, "hold1");
      step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, "hold2");
      chk("hold head", out_instr, 32'h0F0F_1234);

      // PC ordering: two words, drain in order.
      step(1'b1, 1'b0, 1'b0, 32'h5555_0005, 32'h0040_0004, "pc_push2");
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "pc_pop1");
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "pc_pop2");

      // Asynchronous reset between edges with a full buffer.
      step(1'b1, 1'b0, 1'b0, 32'h7777_0007, 32'h0040_0010, "rst_fill1");
      step(1'b1, 1'b0, 1'b0, 32'h8888_0008, 32'h0040_0014, "rst_fill2");
      chk("rst full count", {30'd0, out_count}, 32'd2);
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      sb.delete();
      check_model("async_rst");
      #2;
      reset_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'h9999_0009, 32'h0040_0020, "post_rst_push");
      chk("post rst instr", out_instr, 32'h9999_0009);
      step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "post_rst_pop");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
